// File: rtl/io_hub_pkg.sv
// Shared constants for io_hub: register byte offsets, TCTRL bit positions and the
// active-low hex-to-7-segment table ({g,f,e,d,c,b,a}).
package io_hub_pkg;

  localparam logic [7:0] OffSw     = 8'h00;
  localparam logic [7:0] OffKey    = 8'h04;
  localparam logic [7:0] OffKeyEvt = 8'h08;
  localparam logic [7:0] OffLed    = 8'h0C;
  localparam logic [7:0] OffSeg0   = 8'h10;
  localparam logic [7:0] OffTcnt   = 8'h30;
  localparam logic [7:0] OffTcmp   = 8'h34;
  localparam logic [7:0] OffTctrl  = 8'h38;

  localparam int unsigned TctrlEn  = 0;
  localparam int unsigned TctrlAr  = 1;
  localparam int unsigned TctrlIe  = 2;
  localparam int unsigned TctrlExp = 3;

  localparam logic [6:0] SegBlank = 7'h7F;

  // Index 15 first: F, E, d, C, b, A, 9 .. 0.
  localparam logic [15:0][6:0] SegTable = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bit 4 of a digit register blanks the digit.
  function automatic logic [6:0] seg_decode(input logic [4:0] v);
    return v[4] ? SegBlank : SegTable[v[3:0]];
  endfunction

endpackage

// File: rtl/io_hub_if.sv
// CPU data-port bus as seen by io_hub: address/store data in, load data out, and the
// store strobe / read data toward data memory.
interface io_hub_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;

  modport master (
    output addr, wdata, cpu_we, dmem_rdata,
    input  cpu_rdata, dmem_we
  );

  modport slave (
    input  addr, wdata, cpu_we, dmem_rdata,
    output cpu_rdata, dmem_we
  );
endinterface

// File: rtl/key_debounce.sv
// Single-key debouncer: accepts a new level after DEB_CYCLES consecutive differing
// samples; press pulses on the edge where a 0->1 change is accepted.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            differ, done;

  assign differ = (din != level_q);
  assign done   = differ && (cnt_q == CntW'(DEB_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (done) begin
      level_d = din;
    end else if (differ) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign press = done & din;

endmodule

// File: rtl/io_hub.sv
// Memory-mapped I/O hub: splits CPU data accesses between data memory and the I/O
// register window. Define IO_HUB_TIMER_EN to build the compare timer at 0x30-0x38.
module io_hub
  import io_hub_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int unsigned N_SW       = 10,
  parameter int unsigned N_KEY      = 4,
  parameter int unsigned N_LED      = 10,
  parameter int unsigned N_SEG      = 6,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               resetn,
  io_hub_if.slave            bus,
  input  logic [N_SW-1:0]    sw_i,
  input  logic [N_KEY-1:0]   key_i,
  output logic [N_LED-1:0]   led_o,
  output logic [7*N_SEG-1:0] seg_o,
  output logic               timer_irq_o
);

  logic       hit, wr;
  logic [7:0] off;
  logic       unused_bits;

  assign hit         = (bus.addr[31:8] == IO_BASE[31:8]);
  assign off         = {bus.addr[7:2], 2'b00};
  assign wr          = bus.cpu_we & hit;
  assign bus.dmem_we = bus.cpu_we & ~hit;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  // Input synchronisers; raw keys are active-low so released is all ones.
  logic [N_SW-1:0]  sw_s1_q, sw_s_q;
  logic [N_KEY-1:0] key_s1_q, key_s_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q  <= '0;
      sw_s_q   <= '0;
      key_s1_q <= '1;
      key_s_q  <= '1;
    end else begin
      sw_s1_q  <= sw_i;
      sw_s_q   <= sw_s1_q;
      key_s1_q <= key_i;
      key_s_q  <= key_s1_q;
    end
  end

  logic [N_KEY-1:0] key_lvl, key_press;

  for (genvar k = 0; k < N_KEY; k++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock (clock),
      .resetn(resetn),
      .din   (~key_s_q[k]),
      .level (key_lvl[k]),
      .press (key_press[k])
    );
  end

  logic [N_KEY-1:0] evt_q, evt_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [4:0]       seg_q [N_SEG];
  logic [4:0]       seg_d [N_SEG];

  // A fresh press beats a W1C clear of the same bit.
  always_comb begin
    evt_d = evt_q;
    if (wr && (off == OffKeyEvt)) begin
      evt_d = evt_q & ~bus.wdata[N_KEY-1:0];
    end
    evt_d = evt_d | key_press;

    led_d = led_q;
    if (wr && (off == OffLed)) begin
      led_d = bus.wdata[N_LED-1:0];
    end

    for (int i = 0; i < N_SEG; i++) begin
      seg_d[i] = seg_q[i];
      if (wr && (off == OffSeg0 + 8'(4 * i))) begin
        seg_d[i] = bus.wdata[4:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evt_q <= '0;
      led_q <= '0;
      for (int i = 0; i < N_SEG; i++) begin
        seg_q[i] <= 5'h10;
      end
    end else begin
      evt_q <= evt_d;
      led_q <= led_d;
      for (int i = 0; i < N_SEG; i++) begin
        seg_q[i] <= seg_d[i];
      end
    end
  end

  assign led_o = led_q;

  always_comb begin
    seg_o = '1;
    for (int i = 0; i < N_SEG; i++) begin
      seg_o[7*i +: 7] = seg_decode(seg_q[i]);
    end
  end

`ifdef IO_HUB_TIMER_EN
  logic [31:0] tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic [3:0]  tctrl_q, tctrl_d;
  logic        match;

  assign match = tctrl_q[TctrlEn] && (tcnt_q == tcmp_q);

  // CPU writes override the counter's own update for the written fields only.
  always_comb begin
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    if (match) begin
      if (tctrl_q[TctrlAr]) begin
        tcnt_d = '0;
      end else begin
        tctrl_d[TctrlEn] = 1'b0;
      end
    end else if (tctrl_q[TctrlEn]) begin
      tcnt_d = tcnt_q + 32'd1;
    end
    if (wr && (off == OffTcnt)) begin
      tcnt_d = bus.wdata;
    end
    if (wr && (off == OffTcmp)) begin
      tcmp_d = bus.wdata;
    end
    if (wr && (off == OffTctrl)) begin
      tctrl_d[TctrlEn] = bus.wdata[TctrlEn];
      tctrl_d[TctrlAr] = bus.wdata[TctrlAr];
      tctrl_d[TctrlIe] = bus.wdata[TctrlIe];
      if (bus.wdata[TctrlExp]) begin
        tctrl_d[TctrlExp] = 1'b0;
      end
    end
    if (match) begin
      tctrl_d[TctrlExp] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      tctrl_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
    end
  end

  assign timer_irq_o = tctrl_q[TctrlExp] & tctrl_q[TctrlIe];
`else
  assign timer_irq_o = 1'b0;
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (off)
      OffSw:     rdata[N_SW-1:0]  = sw_s_q;
      OffKey:    rdata[N_KEY-1:0] = key_lvl;
      OffKeyEvt: rdata[N_KEY-1:0] = evt_q;
      OffLed:    rdata[N_LED-1:0] = led_q;
`ifdef IO_HUB_TIMER_EN
      OffTcnt:   rdata            = tcnt_q;
      OffTcmp:   rdata            = tcmp_q;
      OffTctrl:  rdata[3:0]       = tctrl_q;
`endif
      default: begin
        for (int i = 0; i < N_SEG; i++) begin
          if (off == OffSeg0 + 8'(4 * i)) begin
            rdata[4:0] = seg_q[i];
          end
        end
      end
    endcase
  end

  assign bus.cpu_rdata = hit ? rdata : bus.dmem_rdata;

endmodule
